rv_decode_stage: RTL and testbench
==================================

Name: rv_decode_stage

Overview:
Parametrised, registered RV32I/RV64I instruction decode stage with valid/ready handshakes on both sides.
- Accepts a fetched 32-bit word and its PC, with optional byte-order swap.
- Classifies instruction format, extracts register fields and emits one format-selected, sign-extended XLEN immediate.
- Flags illegal encodings.
- Sits between the fetch/memory interface and the execute/register-file stage; supports stall back-pressure and pipeline flush.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64; OP-IMM-32/OP-32 legal only when 64
BYTE_SWAP, 1, 1 = instr_i arrives big-endian and is byte-reversed before decode; 0 = used as-is

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
flush_i  in  1  discard held/incoming instruction
in_valid_i  in  1  instr_i/pc_i valid
in_ready_o  out  1  stage can accept
instr_i  in  32  raw fetched word
pc_i  in  XLEN  PC of instr_i
out_valid_o  out  1  decoded bundle valid
out_ready_i  in  1  consumer accepts
pc_o  out  XLEN  PC of decoded instruction
opcode_o  out  7  instr[6:0]
funct3_o  out  3  instr[14:12]
funct7_o  out  7  instr[31:25]
rd_o, rs1_o, rs2_o  out  5 each  register indices
imm_o  out  XLEN  sign-extended immediate for fmt_o
fmt_o  out  3  format code (package enum)
rd_we_o  out  1  instruction writes rd
illegal_o  out  1  illegal encoding

Behaviour:
- Reset (async assert, sync release): out_valid_o=0; every other output = 0; skid (if present) empty.
- Latency: 1 cycle. Accept = in_valid_i & in_ready_o; the decoded bundle is registered and out_valid_o=1 the next cycle.
- Handshake, base build: in_ready_o = !out_valid_o | out_ready_i (combinational).
  - While out_valid_o & !out_ready_i, all outputs hold stable.
  - Simultaneous consume and accept: the new bundle replaces the old one with no bubble.
- Flush: out_valid_o=0 next cycle.
  - Any accept in the flush cycle is discarded.
  - Flush takes priority over accept and hold.
  - in_ready_o is unaffected by flush.
- Format by opcode:
  - 0110111/0010111 -> U
  - 1101111 -> J
  - 1100111, 0000011, 0010011, 0001111, 1110011 -> I
  - 1100011 -> B
  - 0100011 -> S
  - 0110011 -> R
  - 0011011 -> I and 0111011 -> R only if XLEN==64
  - anything else, or instr[1:0]!=2'b11 -> ILL
- Immediates (bit 31 sign-extended to XLEN):
  - I = instr[31:20]
  - S = {instr[31:25], instr[11:7]}
  - B = {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - U = {instr[31:12], 12'b0}
  - J = {instr[31], instr[19:12], instr[20], instr[30:21], 0}
  - R and ILL -> 0
- rd_we_o = 1 for fmt R/I/U/J with rd!=0; 0 for S, B, ILL.
- Illegal: the bundle is still delivered with illegal_o=1, rd_we_o=0, imm_o=0; field outputs still carry the raw slices.

Optional Feature:
RV_DECODE_SKID_EN
- Defined: adds a 1-entry skid buffer.
  - in_ready_o is a register = !skid_full, with no combinational path from out_ready_i.
  - An accept while the output is stalled lands in the skid; the skid drains to the output when it is consumed.
  - Flush empties both the output stage and the skid.
  - Ordering is preserved.
- Undefined: base combinational-ready behaviour above.

Decomposition:
- Package rv_decode_pkg holds:
  - opcode localparams
  - fmt_e enum: R=0, I=1, S=2, B=3, U=4, J=5, ILL=7
  - dec_bundle_t struct (pc, fields, imm, fmt, rd_we, illegal), parametrised via XLEN-width typedef
- Sub-module rv_imm_gen: combinational instr + fmt -> XLEN immediate.
- Stage register and skid stay in the top module.

Test Plan:
- BYTE_SWAP=1, instr_i=0x9300F1FF (addi x1,x2,-1), pc_i=0x100 -> next cycle: fmt=I, rd=1, rs1=2, imm=0xFFFFFFFF, rd_we=1, pc_o=0x100.
- BYTE_SWAP=0, stream 0x00512423 (sw x5,8(x2)), 0xFE000EE3 (beq -4), 0x001000EF (jal x1,2048) -> fmt S/imm 8/rd_we 0; fmt B/imm 0xFFFFFFFC; fmt J/imm 0x800/rd_we 1.
- XLEN=64: 0xABCDE1B7 (lui x3) -> imm=0xFFFFFFFFABCDE000. Opcode 0x0000001B is legal at XLEN=64 and illegal_o=1 at XLEN=32.
- out_ready_i=0 for 3 cycles with in_valid_i=1 -> outputs stable, no accept. Base build: in_ready_o=0. Skid build: exactly one extra word accepted, then in_ready_o=0. Releasing out_ready_i delivers both words in order.
- flush_i together with an accept while out_valid_o=1 -> out_valid_o=0 next cycle, neither word is ever delivered, and in_ready_o=1 after.
- Reset asserted mid-stall, asynchronously -> out_valid_o and all outputs drop to 0 the same cycle; first post-reset accept decodes correctly.

Source files
------------

// File: rtl/rv_decode_pkg.sv
// Purpose: shared opcodes, format enum, decoded-field struct and decode helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package rv_decode_pkg;

  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_IMM      = 7'b0010011;
  localparam logic [6:0] OP_IMM32    = 7'b0011011;
  localparam logic [6:0] OP_OP       = 7'b0110011;
  localparam logic [6:0] OP_OP32     = 7'b0111011;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ILL = 3'd7
  } fmt_e;

  // XLEN-independent part of the decoded bundle; pc/imm are added by the
  // stage because their width follows the stage's XLEN parameter.
  typedef struct packed {
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    fmt_e       fmt;
    logic       rd_we;
    logic       illegal;
  } dec_fields_t;

  function automatic logic [31:0] byte_swap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // The *-32 opcodes only exist in RV64.
  function automatic fmt_e decode_fmt(input logic [31:0] instr, input logic rv64);
    fmt_e f;
    f = FMT_ILL;
    if (instr[1:0] == 2'b11) begin
      case (instr[6:0])
        OP_LUI, OP_AUIPC:                             f = FMT_U;
        OP_JAL:                                       f = FMT_J;
        OP_JALR, OP_LOAD, OP_IMM, OP_MISC_MEM,
        OP_SYSTEM:                                    f = FMT_I;
        OP_BRANCH:                                    f = FMT_B;
        OP_STORE:                                     f = FMT_S;
        OP_OP:                                        f = FMT_R;
        OP_IMM32:                                     f = rv64 ? FMT_I : FMT_ILL;
        OP_OP32:                                      f = rv64 ? FMT_R : FMT_ILL;
        default:                                      f = FMT_ILL;
      endcase
    end
    return f;
  endfunction

endpackage

// File: rtl/rv_imm_gen.sv
// Purpose: format-selected immediate extraction, sign-extended to XLEN.
// Latency: combinational.
// Backpressure: n/a.
// Ports: instr (decoded-order word), fmt (format code) -> imm (XLEN, 0 for R/ILL).
module rv_imm_gen
  import rv_decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  fmt_e            fmt,
  output logic [XLEN-1:0] imm
);

  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (fmt)
      FMT_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   imm32 = {instr[31:12], 12'b0};
      FMT_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  // imm32[31] already carries the sign for every format that has one.
  generate
    if (XLEN > 32) begin : g_ext
      assign imm = {{(XLEN-32){imm32[31]}}, imm32};
    end else begin : g_noext
      assign imm = imm32;
    end
  endgenerate

endmodule

// File: rtl/rv_decode_stage.sv
// Purpose: registered RV32I/RV64I decode stage (format, fields, immediate, illegal flag).
// Latency: 1 cycle from accept to out_valid_o.
// Backpressure: valid/ready both sides; outputs hold while stalled; flush_i drops held data.
// Ports: clk_i, rst_i (async, active-high), flush_i; in_valid_i/in_ready_o, instr_i, pc_i;
//        out_valid_o/out_ready_i, pc_o, opcode_o, funct3_o, funct7_o, rd_o, rs1_o, rs2_o,
//        imm_o, fmt_o, rd_we_o, illegal_o.
// Option: define RV_DECODE_SKID_EN for a 1-entry skid buffer with a registered in_ready_o.
module rv_decode_stage
  import rv_decode_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit BYTE_SWAP = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] pc_o,
  output logic [6:0]      opcode_o,
  output logic [2:0]      funct3_o,
  output logic [6:0]      funct7_o,
  output logic [4:0]      rd_o,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  output logic [XLEN-1:0] imm_o,
  output logic [2:0]      fmt_o,
  output logic            rd_we_o,
  output logic            illegal_o
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    dec_fields_t     f;
  } dec_bundle_t;

  logic [31:0]     instr;
  fmt_e            fmt;
  logic [XLEN-1:0] imm;
  dec_bundle_t     dec_d;
  dec_bundle_t     out_q;
  logic            accept;

  assign instr  = BYTE_SWAP ? byte_swap32(instr_i) : instr_i;
  assign fmt    = decode_fmt(instr, XLEN == 64);
  assign accept = in_valid_i & in_ready_o;

  rv_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (instr),
    .fmt   (fmt),
    .imm   (imm)
  );

  always_comb begin
    dec_d          = '0;
    dec_d.pc       = pc_i;
    dec_d.imm      = imm;
    dec_d.f.opcode = instr[6:0];
    dec_d.f.funct3 = instr[14:12];
    dec_d.f.funct7 = instr[31:25];
    dec_d.f.rd     = instr[11:7];
    dec_d.f.rs1    = instr[19:15];
    dec_d.f.rs2    = instr[24:20];
    dec_d.f.fmt    = fmt;
    dec_d.f.illegal = (fmt == FMT_ILL);
    // Writes to x0 are architecturally discarded, so report them as no-write.
    dec_d.f.rd_we  = ((fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_U) || (fmt == FMT_J))
                     && (instr[11:7] != 5'd0);
  end

`ifdef RV_DECODE_SKID_EN
  logic        skid_vld;
  dec_bundle_t skid_q;
  logic        out_free;

  // Ready depends only on skid occupancy, which is a flop: no path from out_ready_i.
  assign in_ready_o = !skid_vld;
  assign out_free   = !out_valid_o | out_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_o <= 1'b0;
      out_q       <= '0;
      skid_vld    <= 1'b0;
      skid_q      <= '0;
    end else if (flush_i) begin
      out_valid_o <= 1'b0;
      skid_vld    <= 1'b0;
    end else if (out_free) begin
      if (skid_vld) begin
        // Skid is older than anything arriving now; it goes out first.
        // accept is 0 here because in_ready_o is low while the skid is full.
        out_q       <= skid_q;
        out_valid_o <= 1'b1;
        skid_vld    <= 1'b0;
      end else begin
        out_valid_o <= accept;
        if (accept) out_q <= dec_d;
      end
    end else if (accept) begin
      skid_vld <= 1'b1;
      skid_q   <= dec_d;
    end
  end
`else
  assign in_ready_o = !out_valid_o | out_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_o <= 1'b0;
      out_q       <= '0;
    end else if (flush_i) begin
      out_valid_o <= 1'b0;
    end else if (accept) begin
      out_valid_o <= 1'b1;
      out_q       <= dec_d;
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end
`endif

  assign pc_o      = out_q.pc;
  assign imm_o     = out_q.imm;
  assign opcode_o  = out_q.f.opcode;
  assign funct3_o  = out_q.f.funct3;
  assign funct7_o  = out_q.f.funct7;
  assign rd_o      = out_q.f.rd;
  assign rs1_o     = out_q.f.rs1;
  assign rs2_o     = out_q.f.rs2;
  assign fmt_o     = out_q.f.fmt;
  assign rd_we_o   = out_q.f.rd_we;
  assign illegal_o = out_q.f.illegal;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Purpose: self-checking bench for rv_decode_stage (RV32 little-endian and RV64 byte-swapped copies).
// Latency: checks 1-cycle accept-to-valid via scoreboard.
// Backpressure: exercises stalls, flush, async reset and random out_ready.
module tb_rv_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic [31:0] instr_sw;
  logic [63:0] pc;

  always #5 clk = ~clk;
  assign instr_sw = {instr[7:0], instr[15:8], instr[23:16], instr[31:24]};

  // DUT A: XLEN=32, no swap.
  logic        a_in_ready, a_out_valid, a_rd_we, a_illegal;
  logic [31:0] a_pc, a_imm;
  logic [6:0]  a_opcode, a_funct7;
  logic [2:0]  a_funct3, a_fmt;
  logic [4:0]  a_rd, a_rs1, a_rs2;

  // DUT B: XLEN=64, big-endian input (fed the byte-reversed word).
  logic        b_in_ready, b_out_valid, b_rd_we, b_illegal;
  logic [63:0] b_pc, b_imm;
  logic [6:0]  b_opcode, b_funct7;
  logic [2:0]  b_funct3, b_fmt;
  logic [4:0]  b_rd, b_rs1, b_rs2;

  rv_decode_stage #(.XLEN(32), .BYTE_SWAP(1'b0)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(a_in_ready),
    .instr_i(instr), .pc_i(pc[31:0]), .out_valid_o(a_out_valid), .out_ready_i(out_ready),
    .pc_o(a_pc), .opcode_o(a_opcode), .funct3_o(a_funct3), .funct7_o(a_funct7),
    .rd_o(a_rd), .rs1_o(a_rs1), .rs2_o(a_rs2), .imm_o(a_imm), .fmt_o(a_fmt),
    .rd_we_o(a_rd_we), .illegal_o(a_illegal)
  );

  rv_decode_stage #(.XLEN(64), .BYTE_SWAP(1'b1)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(b_in_ready),
    .instr_i(instr_sw), .pc_i(pc), .out_valid_o(b_out_valid), .out_ready_i(out_ready),
    .pc_o(b_pc), .opcode_o(b_opcode), .funct3_o(b_funct3), .funct7_o(b_funct7),
    .rd_o(b_rd), .rs1_o(b_rs1), .rs2_o(b_rs2), .imm_o(b_imm), .fmt_o(b_fmt),
    .rd_we_o(b_rd_we), .illegal_o(b_illegal)
  );

  int checks = 0;
  int errors = 0;
  int delivered = 0;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] w;
    logic [2:0]  fmt32, fmt64;
    logic [63:0] imm32, imm64;
    logic        we32, we64;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  function automatic logic [2:0] ref_fmt(input logic [31:0] w, input bit rv64);
    if (w[1:0] != 2'b11) return 3'd7;
    case (w[6:0])
      7'h37, 7'h17:                      return 3'd4;
      7'h6F:                             return 3'd5;
      7'h67, 7'h03, 7'h13, 7'h0F, 7'h73: return 3'd1;
      7'h63:                             return 3'd3;
      7'h23:                             return 3'd2;
      7'h33:                             return 3'd0;
      7'h1B:                             return rv64 ? 3'd1 : 3'd7;
      7'h3B:                             return rv64 ? 3'd0 : 3'd7;
      default:                           return 3'd7;
    endcase
  endfunction

  function automatic logic [63:0] ref_imm(input logic [31:0] w, input logic [2:0] f);
    case (f)
      3'd1: return {{52{w[31]}}, w[31:20]};
      3'd2: return {{52{w[31]}}, w[31:25], w[11:7]};
      3'd3: return {{51{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      3'd4: return {{32{w[31]}}, w[31:12], 12'h000};
      3'd5: return {{43{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default: return 64'd0;
    endcase
  endfunction

  function automatic exp_t ref_decode(input logic [31:0] w, input logic [63:0] p);
    exp_t e;
    e.pc    = p;
    e.w     = w;
    e.fmt32 = ref_fmt(w, 1'b0);
    e.fmt64 = ref_fmt(w, 1'b1);
    e.imm32 = ref_imm(w, e.fmt32);
    e.imm64 = ref_imm(w, e.fmt64);
    e.we32  = (e.fmt32 inside {3'd0, 3'd1, 3'd4, 3'd5}) && (w[11:7] != 5'd0);
    e.we64  = (e.fmt64 inside {3'd0, 3'd1, 3'd4, 3'd5}) && (w[11:7] != 5'd0);
    return e;
  endfunction

  // Scoreboard: pops/compares on output handshake, clears on flush/reset, pushes on accept.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
    end else begin
      checks++;
      if (a_in_ready !== b_in_ready || a_out_valid !== b_out_valid) begin
        errors++;
        $display("FAIL dut_sync: a rdy/vld=%b%b b rdy/vld=%b%b (must match)",
                 a_in_ready, a_out_valid, b_in_ready, b_out_valid);
      end
      if (a_out_valid && out_ready && !flush) begin
        delivered++;
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: output pc=%h delivered with nothing expected", a_pc);
        end else begin
          mon_e = sb_q.pop_front();
          if ({a_pc, a_opcode, a_funct3, a_funct7, a_rd, a_rs1, a_rs2, a_imm, a_fmt, a_rd_we, a_illegal}
              !== {mon_e.pc[31:0], mon_e.w[6:0], mon_e.w[14:12], mon_e.w[31:25], mon_e.w[11:7],
                   mon_e.w[19:15], mon_e.w[24:20], mon_e.imm32[31:0], mon_e.fmt32, mon_e.we32,
                   mon_e.fmt32 == 3'd7}) begin
            errors++;
            $display("FAIL sb_rv32: w=%h got pc=%h fmt=%0d imm=%h we=%b ill=%b rd=%0d, expected pc=%h fmt=%0d imm=%h we=%b",
                     mon_e.w, a_pc, a_fmt, a_imm, a_rd_we, a_illegal, a_rd,
                     mon_e.pc[31:0], mon_e.fmt32, mon_e.imm32[31:0], mon_e.we32);
          end
          checks++;
          if ({b_pc, b_opcode, b_funct3, b_funct7, b_rd, b_rs1, b_rs2, b_imm, b_fmt, b_rd_we, b_illegal}
              !== {mon_e.pc, mon_e.w[6:0], mon_e.w[14:12], mon_e.w[31:25], mon_e.w[11:7],
                   mon_e.w[19:15], mon_e.w[24:20], mon_e.imm64, mon_e.fmt64, mon_e.we64,
                   mon_e.fmt64 == 3'd7}) begin
            errors++;
            $display("FAIL sb_rv64: w=%h got pc=%h fmt=%0d imm=%h we=%b ill=%b rd=%0d, expected pc=%h fmt=%0d imm=%h we=%b",
                     mon_e.w, b_pc, b_fmt, b_imm, b_rd_we, b_illegal, b_rd,
                     mon_e.pc, mon_e.fmt64, mon_e.imm64, mon_e.we64);
          end
        end
      end
      if (flush) sb_q.delete();
      else if (in_valid && a_in_ready) sb_q.push_back(ref_decode(instr, pc));
    end
  end

  // Drives one word and waits (bounded) for it to be accepted. Starts/ends at posedge+1.
  task automatic send(input logic [31:0] w, input logic [63:0] p);
    int n;
    n = 0;
    instr = w;
    pc = p;
    in_valid = 1'b1;
    @(negedge clk);
    while (!a_in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL send_timeout: w=%h in_ready=%b after %0d cycles, required 1", w, a_in_ready, n);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain(input int expect_total);
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((sb_q.size() != 0 || delivered < expect_total) && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (sb_q.size() != 0 || delivered != expect_total) begin
      errors++;
      $display("FAIL drain: pending=%0d delivered=%0d, required pending=0 delivered=%0d",
               sb_q.size(), delivered, expect_total);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instr = 32'h0; pc = 64'h0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({a_out_valid, a_pc, a_imm, a_fmt, a_rd, a_rs1, a_rs2, a_opcode, a_rd_we, a_illegal} !== '0 ||
        {b_out_valid, b_pc, b_imm, b_fmt, b_rd_we, b_illegal} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: a_vld=%b a_pc=%h b_vld=%b b_imm=%h, required all 0",
               a_out_valid, a_pc, b_out_valid, b_imm);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: out_valid=%b in_ready=%b, required 0/1", a_out_valid, a_in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_addi_swap();
    out_ready = 1'b1;
    send(32'hFFF10093, 64'h100);   // DUT B sees 0x9300F1FF
    @(negedge clk);
    checks++;
    if ({b_out_valid, b_fmt, b_rd, b_rs1, b_imm, b_rd_we, b_pc} !==
        {1'b1, 3'd1, 5'd1, 5'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'h100}) begin
      errors++;
      $display("FAIL addi_swap: vld=%b fmt=%0d rd=%0d rs1=%0d imm=%h we=%b pc=%h, required 1/1/1/2/all-ones/1/100",
               b_out_valid, b_fmt, b_rd, b_rs1, b_imm, b_rd_we, b_pc);
    end
    checks++;
    if (a_imm !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL addi_rv32_imm: imm=%h, required ffffffff", a_imm);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_formats();
    logic [31:0] w   [3] = '{32'h00512423, 32'hFE000EE3, 32'h001000EF};
    logic [2:0]  f   [3] = '{3'd2, 3'd3, 3'd5};
    logic [31:0] imm [3] = '{32'h8, 32'hFFFF_FFFC, 32'h800};
    logic        we  [3] = '{1'b0, 1'b0, 1'b1};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(w[i], 64'h200 + 64'(4 * i));
      @(negedge clk);
      checks++;
      if (a_out_valid !== 1'b1 || a_fmt !== f[i] || a_imm !== imm[i] || a_rd_we !== we[i]) begin
        errors++;
        $display("FAIL format_%0d: w=%h vld=%b fmt=%0d imm=%h we=%b, required 1/%0d/%h/%b",
                 i, w[i], a_out_valid, a_fmt, a_imm, a_rd_we, f[i], imm[i], we[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rv64();
    out_ready = 1'b1;
    send(32'hABCDE1B7, 64'h3000);
    @(negedge clk);
    checks++;
    if (b_imm !== 64'hFFFF_FFFF_ABCD_E000 || b_fmt !== 3'd4 || b_rd !== 5'd3 || a_imm !== 32'hABCD_E000) begin
      errors++;
      $display("FAIL lui64: b_imm=%h b_fmt=%0d b_rd=%0d a_imm=%h, required ffffffffabcde000/4/3/abcde000",
               b_imm, b_fmt, b_rd, a_imm);
    end
    @(posedge clk); #1;
    send(32'h0000001B, 64'h3004);
    @(negedge clk);
    checks++;
    if (a_illegal !== 1'b1 || a_fmt !== 3'd7 || a_rd_we !== 1'b0 || a_imm !== 32'h0 || a_opcode !== 7'h1B) begin
      errors++;
      $display("FAIL op_imm32_rv32: ill=%b fmt=%0d we=%b imm=%h op=%h, required 1/7/0/0/1b",
               a_illegal, a_fmt, a_rd_we, a_imm, a_opcode);
    end
    checks++;
    if (b_illegal !== 1'b0 || b_fmt !== 3'd1) begin
      errors++;
      $display("FAIL op_imm32_rv64: ill=%b fmt=%0d, required 0/1", b_illegal, b_fmt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stall();
    logic [31:0] w [4] = '{32'h00A00093, 32'h01400113, 32'h01E00193, 32'h02800213};
    int acc, d0, exp_acc;
`ifdef RV_DECODE_SKID_EN
    exp_acc = 1;
`else
    exp_acc = 0;
`endif
    d0 = delivered;
    acc = 0;
    out_ready = 1'b0;
    in_valid = 1'b1;
    instr = w[0];
    pc = 64'h400;
    @(posedge clk); #1;
    instr = w[1];
    pc = 64'h404;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (a_out_valid !== 1'b1 || a_pc !== 32'h400 || a_rd !== 5'd1 || a_imm !== 32'd10 || b_pc !== 64'h400) begin
        errors++;
        $display("FAIL stall_hold_%0d: vld=%b pc=%h rd=%0d imm=%h, required 1/400/1/a", c, a_out_valid, a_pc, a_rd, a_imm);
      end
      checks++;
      if (a_in_ready !== (c < exp_acc)) begin
        errors++;
        $display("FAIL stall_ready_%0d: in_ready=%b, required %b", c, a_in_ready, c < exp_acc);
      end
      if (a_in_ready) acc++;
      @(posedge clk); #1;
      instr = w[1 + acc];
      pc = 64'h404 + 64'(4 * acc);
    end
    checks++;
    if (acc != exp_acc) begin
      errors++;
      $display("FAIL stall_accepts: accepted %0d extra words, required %0d", acc, exp_acc);
    end
    in_valid = 1'b0;
    drain(d0 + 1 + exp_acc);
  endtask

  task automatic test_flush();
    int d0;
    d0 = delivered;
    out_ready = 1'b0;
    in_valid = 1'b1;
    instr = 32'h00A00093; pc = 64'h500;
    @(posedge clk); #1;
    instr = 32'h01400113; pc = 64'h504;
    @(posedge clk); #1;
    flush = 1'b1;
    out_ready = 1'b1;
    instr = 32'h01E00193; pc = 64'h508;
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_state: a_vld=%b b_vld=%b in_ready=%b, required 0/0/1", a_out_valid, b_out_valid, a_in_ready);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (a_out_valid !== 1'b0 || delivered != d0) begin
      errors++;
      $display("FAIL flush_discard: vld=%b delivered=%0d, required 0/%0d", a_out_valid, delivered, d0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    send(32'hFFF10093, 64'h600);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({a_out_valid, a_pc, a_imm, a_fmt, a_rd, a_rs1, a_rs2, a_opcode, a_funct3, a_funct7, a_rd_we, a_illegal} !== '0 ||
        {b_out_valid, b_pc, b_imm, b_fmt, b_rd, b_rd_we, b_illegal} !== '0) begin
      errors++;
      $display("FAIL async_reset: a_vld=%b a_pc=%h a_imm=%h b_vld=%b b_pc=%h, required all 0",
               a_out_valid, a_pc, a_imm, b_out_valid, b_pc);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    send(32'h01400113, 64'h700);
    @(negedge clk);
    checks++;
    if (a_out_valid !== 1'b1 || a_rd !== 5'd2 || a_imm !== 32'd20 || a_pc !== 32'h700 || b_imm !== 64'd20) begin
      errors++;
      $display("FAIL post_reset_decode: vld=%b rd=%0d imm=%h pc=%h b_imm=%h, required 1/2/14/700/14",
               a_out_valid, a_rd, a_imm, a_pc, b_imm);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [6:0] ops [10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h63, 7'h23, 7'h33, 7'h3B};
    bit done;
    int d0;
    done = 1'b0;
    d0 = delivered;
    fork
      begin
        logic [31:0] r;
        int k;
        for (int i = 0; i < 24; i++) begin
          r = $urandom();
          k = $urandom_range(0, 10);
          send((k == 10) ? r : {r[31:7], ops[k]}, 64'h1000 + 64'(4 * i));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 1) == 1);
        end
      end
    join
    drain(d0 + 24);
  endtask

  initial begin
    test_reset();
    test_addi_swap();
    test_formats();
    test_rv64();
    test_stall();
    test_flush();
    test_async_reset();
    test_back_to_back();
    repeat (2) @(posedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d expected words never delivered, required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
